// File: rtl/adc_frame_packer_pkg.sv
// Shared widths, word layout and FSM encoding for the ADC frame packer.
// Headers and data words are assembled here so both layouts live in one place.
package adc_frame_pkg;

    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 32;
    localparam int SEQ_W    = 16;
    localparam int CNT_W    = 16;
    localparam int IDX_W    = 8;
    localparam int DROP_W   = 16;

    localparam logic [7:0] MARKER_DEFAULT = 8'hA5;

    localparam int HDR_MARKER_LSB = 24;
    localparam int HDR_SEQ_LSB    = 8;
    localparam int HDR_FLAGS_LSB  = 0;
    localparam int DATA_IDX_LSB   = 24;
    localparam int DATA_SMP_LSB   = 0;

    localparam int FLAG_DROP = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DROP
    } state_t;

    function automatic logic [WORD_W-1:0] make_header(input logic [7:0]       marker,
                                                      input logic [SEQ_W-1:0] seq,
                                                      input logic             drop);
        logic [WORD_W-1:0] w;
        w = '0;
        w[HDR_MARKER_LSB +: 8]         = marker;
        w[HDR_SEQ_LSB +: SEQ_W]        = seq;
        w[HDR_FLAGS_LSB + FLAG_DROP]   = drop;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] make_data(input logic [IDX_W-1:0]    idx,
                                                    input logic [SAMPLE_W-1:0] sample);
        logic [WORD_W-1:0] w;
        w = '0;
        w[DATA_IDX_LSB +: IDX_W]    = idx;
        w[DATA_SMP_LSB +: SAMPLE_W] = sample;
        return w;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample input, FIFO write port and status of the ADC frame packer.
// The packer takes the slave side; the sample source / FIFO side takes the master side.
interface adc_frame_packer_if;
    import adc_frame_pkg::*;

    logic                run;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                fifo_full;
    logic [WORD_W-1:0]   fifo_din;
    logic                fifo_wr_en;
    logic                overflow;
    logic [DROP_W-1:0]   frames_dropped;

    modport master (
        output run,
        output sample_data,
        output sample_valid,
        output fifo_full,
        input  fifo_din,
        input  fifo_wr_en,
        input  overflow,
        input  frames_dropped
    );

    modport slave (
        input  run,
        input  sample_data,
        input  sample_valid,
        input  fifo_full,
        output fifo_din,
        output fifo_wr_en,
        output overflow,
        output frames_dropped
    );

endinterface

// File: rtl/adc_frame_packer.sv
// Packs ADC samples into header-prefixed frames for the capture FIFO and drops
// whole frames under backpressure so the host never loses frame alignment.
module adc_frame_packer
    import adc_frame_pkg::*;
#(
    parameter int         FRAME_LEN = 256,
    parameter logic [7:0] MARKER    = MARKER_DEFAULT
) (
    input  logic              capture_clk,
    input  logic              capture_rst_n,
    adc_frame_packer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

    state_t                     state;
    logic                       run_q;
    logic [SEQ_W-1:0]           seq;
    logic [CNT_W-1:0]           cnt;
    logic                       drop_flag;
    logic                       pend_vld;
    logic                       pend_last;
    logic [IDX_W-1:0]           pend_idx;
    logic signed [SAMPLE_W-1:0] pend_data;
    logic [WORD_W-1:0]          din_r;
    logic                       wr_en_r;
    logic                       overflow_r;
    logic [DROP_W-1:0]          dropped_r;

    logic run_rise;
    logic active;
    logic write_pend;
    logic stall_pend;
    logic take;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

    always_comb begin
        run_rise   = bus.run && !run_q;
        active     = bus.run && !run_rise;
        write_pend = (state == ST_DATA) && pend_vld && !bus.fifo_full;
        stall_pend = (state == ST_DATA) && pend_vld && bus.fifo_full;
        // The slot only accepts a sample when it is empty or being written this cycle.
        take       = active && bus.sample_valid &&
                     ((state == ST_IDLE) || ((state == ST_DATA) && !stall_pend));
    end

    always_ff @(posedge capture_clk) begin
        if (take) begin
            pend_data <= $signed(bus.sample_data);
        end
    end

    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            state      <= ST_IDLE;
            run_q      <= 1'b0;
            seq        <= '0;
            cnt        <= '0;
            drop_flag  <= 1'b0;
            pend_vld   <= 1'b0;
            pend_last  <= 1'b0;
            pend_idx   <= '0;
            din_r      <= '0;
            wr_en_r    <= 1'b0;
            overflow_r <= 1'b0;
            dropped_r  <= '0;
        end else begin
            run_q   <= bus.run;
            wr_en_r <= 1'b0;
            if (!active) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                pend_vld  <= 1'b0;
                pend_last <= 1'b0;
                if (run_rise) begin
                    seq        <= '0;
                    overflow_r <= 1'b0;
                    dropped_r  <= '0;
                    drop_flag  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.sample_valid) begin
                            state     <= ST_HDR;
                            pend_vld  <= 1'b1;
                            pend_idx  <= '0;
                            pend_last <= 1'b0;
                            cnt       <= CNT_W'(1);
                        end
                    end

                    ST_HDR: begin
                        // Slot still holds sample 0: a new strobe is lost but keeps its place in the frame.
                        if (bus.sample_valid) begin
                            overflow_r <= 1'b1;
                            if (cnt != FULL_CNT) begin
                                cnt <= cnt + CNT_W'(1);
                                if (cnt == LAST_IDX) begin
                                    pend_last <= 1'b1;
                                end
                            end
                        end
                        if (bus.fifo_full) begin
                            state      <= ST_DROP;
                            pend_vld   <= 1'b0;
                            dropped_r  <= sat_inc(dropped_r);
                            overflow_r <= 1'b1;
                            drop_flag  <= 1'b1;
                        end else begin
                            state   <= ST_DATA;
                            wr_en_r <= 1'b1;
                            din_r   <= make_header(MARKER, seq, drop_flag);
                        end
                    end

                    ST_DATA: begin
                        if (stall_pend) begin
                            state      <= ST_DROP;
                            pend_vld   <= 1'b0;
                            dropped_r  <= sat_inc(dropped_r);
                            overflow_r <= 1'b1;
                            drop_flag  <= 1'b1;
                            if (bus.sample_valid && (cnt != FULL_CNT)) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            if (write_pend) begin
                                wr_en_r  <= 1'b1;
                                din_r    <= make_data(pend_idx, pend_data);
                                pend_vld <= 1'b0;
                            end
                            if (write_pend && pend_last) begin
                                seq       <= seq + SEQ_W'(1);
                                drop_flag <= 1'b0;
                                // A strobe arriving with the last write opens the next frame directly.
                                if (bus.sample_valid) begin
                                    state     <= ST_HDR;
                                    pend_vld  <= 1'b1;
                                    pend_idx  <= '0;
                                    pend_last <= 1'b0;
                                    cnt       <= CNT_W'(1);
                                end else begin
                                    state <= ST_IDLE;
                                    cnt   <= '0;
                                end
                            end else if (bus.sample_valid) begin
                                pend_vld  <= 1'b1;
                                pend_idx  <= cnt[IDX_W-1:0];
                                pend_last <= (cnt == LAST_IDX);
                                cnt       <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_DROP: begin
                        pend_vld <= 1'b0;
                        if (cnt == FULL_CNT) begin
                            state <= ST_IDLE;
                            seq   <= seq + SEQ_W'(1);
                            cnt   <= '0;
                            if (bus.sample_valid) begin
                                overflow_r <= 1'b1;
                            end
                        end else if (bus.sample_valid) begin
                            if (cnt == LAST_IDX) begin
                                state <= ST_IDLE;
                                seq   <= seq + SEQ_W'(1);
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_din       = din_r;
    assign bus.fifo_wr_en     = wr_en_r;
    assign bus.overflow       = overflow_r;
    assign bus.frames_dropped = dropped_r;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with FRAME_LEN=4: framing, drops, run toggling, reset.
module tb_adc_frame_packer;

    logic clk = 1'b0;
    logic rst_n;

    adc_frame_packer_if bus ();

    adc_frame_packer #(
        .FRAME_LEN (4),
        .MARKER    (8'hA5)
    ) dut (
        .capture_clk   (clk),
        .capture_rst_n (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] smp;
        bit          first;
        bit          wr;
        bit          full;
        logic [31:0] hdr;
        logic [31:0] dat;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [23:0] smp, input bit first, input bit wr, input bit full,
                                input logic [31:0] hdr, input logic [31:0] dat);
        vec_t v;
        v.smp = smp; v.first = first; v.wr = wr; v.full = full; v.hdr = hdr; v.dat = dat;
        return v;
    endfunction

    // Compare the write strobe, and the word when a write is expected.
    task automatic check_word(input string nm, input bit en, input logic [31:0] exp);
        logic [32:0] act;
        act = {bus.fifo_wr_en, en ? bus.fifo_din : 32'h0};
        chk(nm, act, {en, en ? exp : 32'h0});
    endtask

    task automatic send(input vec_t v, input string nm);
        @(posedge clk); #1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = v.smp;
        bus.fifo_full    = v.full;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check_word($sformatf("%s_t0", nm), 1'b0, 32'h0);
        if (v.first) begin
            @(negedge clk);
            check_word($sformatf("%s_hdr", nm), v.wr, v.hdr);
        end
        @(negedge clk);
        check_word($sformatf("%s_dat", nm), v.wr, v.dat);
        repeat (5) @(posedge clk);
    endtask

    task automatic check_quiet(input string nm, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_word($sformatf("%s_%0d", nm, c), 1'b0, 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        t1[$];
        vec_t        t2[$];
        logic [31:0] hdr2 [6];

        t1.push_back(mk(24'h000001, 1, 1, 0, 32'hA5000000, 32'h00000001));
        t1.push_back(mk(24'h000002, 0, 1, 0, 32'h0,        32'h01000002));
        t1.push_back(mk(24'h000003, 0, 1, 0, 32'h0,        32'h02000003));
        t1.push_back(mk(24'h000004, 0, 1, 0, 32'h0,        32'h03000004));
        t1.push_back(mk(24'h000005, 1, 1, 0, 32'hA5000100, 32'h00000005));
        t1.push_back(mk(24'h000006, 0, 1, 0, 32'h0,        32'h01000006));
        t1.push_back(mk(24'h000007, 0, 1, 0, 32'h0,        32'h02000007));
        t1.push_back(mk(24'h000008, 0, 1, 0, 32'h0,        32'h03000008));

        // Frame 1 dropped at its header, frame 4 cut after two data words.
        hdr2 = '{32'hA5000000, 32'h0, 32'hA5000201, 32'hA5000300, 32'hA5000400, 32'hA5000501};
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 4; s++) begin
                logic [23:0] smp;
                bit          wr;
                bit          full;
                smp  = 24'((f + 1) * 16 + s);
                wr   = !((f == 1) || (f == 4 && s >= 2));
                full = (f == 1 && s == 0) || (f == 4 && s >= 2);
                t2.push_back(mk(smp, s == 0, wr, full, hdr2[f], {8'(s), smp}));
            end
        end

        rst_n            = 1'b0;
        bus.run          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.fifo_full    = 1'b0;

        #12;
        chk("rst_wr_en",    {32'h0, bus.fifo_wr_en}, 33'h0);
        chk("rst_din",      {1'b0, bus.fifo_din}, 33'h0);
        chk("rst_overflow", {32'h0, bus.overflow}, 33'h0);
        chk("rst_dropped",  {17'h0, bus.frames_dropped}, 33'h0);

        @(negedge clk);
        rst_n   = 1'b1;
        bus.run = 1'b1;
        repeat (3) @(posedge clk);

        foreach (t1[i]) send(t1[i], $sformatf("t1_%0d", i));
        @(negedge clk);
        chk("t1_overflow", {32'h0, bus.overflow}, 33'h0);

        @(posedge clk); #1 bus.run = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.run = 1'b1;
        repeat (3) @(posedge clk);

        foreach (t2[i]) begin
            send(t2[i], $sformatf("t2_%0d", i));
            if (i == 7) begin
                chk("t2_dropped_f1",  {17'h0, bus.frames_dropped}, 33'd1);
                chk("t2_overflow_f1", {32'h0, bus.overflow}, 33'd1);
            end
        end
        bus.fifo_full = 1'b0;
        chk("t3_dropped", {17'h0, bus.frames_dropped}, 33'd2);

        // run falls together with a strobe mid-frame: no write, no drop counted.
        send(mk(24'h000070, 1, 1, 0, 32'hA5000600, 32'h00000070), "t5_a");
        send(mk(24'h000071, 0, 1, 0, 32'h0,        32'h01000071), "t5_b");
        @(posedge clk); #1;
        bus.run          = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 24'h000072;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        check_quiet("t5_quiet", 4);
        chk("t5_dropped_low",  {17'h0, bus.frames_dropped}, 33'd2);
        chk("t5_overflow_low", {32'h0, bus.overflow}, 33'd1);
        @(posedge clk); #1 bus.run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_overflow_clr", {32'h0, bus.overflow}, 33'h0);
        chk("t5_dropped_clr",  {17'h0, bus.frames_dropped}, 33'h0);

        // Two strobes back to back at frame start: second one lost, index still advances.
        @(posedge clk); #1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 24'h000080;
        @(posedge clk); #1;
        bus.sample_data  = 24'h000081;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check_word("t4_hdr", 1'b1, 32'hA5000000);
        @(negedge clk);
        check_word("t4_d0", 1'b1, 32'h00000080);
        chk("t4_overflow", {32'h0, bus.overflow}, 33'd1);
        repeat (5) @(posedge clk);
        send(mk(24'h000082, 0, 1, 0, 32'h0,        32'h02000082), "t4_d2");
        send(mk(24'h000083, 0, 1, 0, 32'h0,        32'h03000083), "t4_d3");
        send(mk(24'h000090, 1, 1, 0, 32'hA5000100, 32'h00000090), "t4_next");

        // Async reset while a data word is on the FIFO port.
        @(posedge clk); #1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 24'h000091;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        @(posedge clk); #2;
        check_word("t6_pre", 1'b1, 32'h01000091);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en",    {32'h0, bus.fifo_wr_en}, 33'h0);
        chk("t6_din",      {1'b0, bus.fifo_din}, 33'h0);
        chk("t6_overflow", {32'h0, bus.overflow}, 33'h0);
        repeat (2) @(negedge clk);
        check_word("t6_hold", 1'b0, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        send(mk(24'h0000A0, 1, 1, 0, 32'hA5000000, 32'h000000A0), "t6_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
